// File: rtl/sha3_absorb_ctrl.sv
// sha3_absorb_ctrl: splits a 64-bit message stream into rate-sized Keccak lane writes,
// appends SHA-3 padding, sequences permutations and hands off to the squeeze stage.
module sha3_absorb_ctrl #(
    parameter int LANE_W = 64
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [LANE_W-1:0] S_TDATA,
    input  logic [7:0]        S_TKEEP,
    input  logic [1:0]        S_TUSER,
    input  logic              S_TVALID,
    input  logic              S_TLAST,
    output logic              S_TREADY,
    output logic              STATE_CLR,
    output logic              LANE_WE,
    output logic [4:0]        LANE_IDX,
    output logic [LANE_W-1:0] LANE_DATA,
    output logic              PERM_START,
    input  logic              PERM_DONE,
    output logic              SQ_READY,
    output logic [1:0]        SQ_TUSER,
    input  logic              SQ_LAST,
    output logic              BUSY
);
    typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_PAD, S_START, S_WAIT, S_SQUEEZE} state_t;

    state_t            r_state;
    logic [4:0]        r_idx;
    logic [1:0]        r_var;
    logic              r_final;
    logic              r_need06;
    logic              r_need80;
    logic              r_fresh;
    logic              r_tready;
    logic              r_clr;
    logic              r_we;
    logic              r_perm;
    logic              r_sq;
    logic              r_busy;
    logic [4:0]        r_lane_idx;
    logic [LANE_W-1:0] r_lane_data;

    logic [4:0]        w_rate_m1;
    logic              w_at_end;
    logic              w_partial;
    logic [7:0]        w_keep_sh;
    logic [LANE_W-1:0] w_lane;

    assign w_rate_m1 = (r_var == 2'd0) ? 5'd17 : (r_var == 2'd1) ? 5'd16 : (r_var == 2'd2) ? 5'd12 : 5'd8;
    assign w_at_end  = (r_idx == w_rate_m1);
    assign w_partial = (S_TKEEP != 8'hFF);
    // byte i is the first invalid byte when keep[i]=0 and keep[i-1]=1 (or i=0)
    assign w_keep_sh = {S_TKEEP[6:0], 1'b1};

    // last-beat lane: valid bytes kept, 0x06 in the first free byte, 0x80 on top when this is the rate's last lane
    always_comb begin
        w_lane = '0;
        for (int i = 0; i < 8; i++)
            w_lane[8*i +: 8] = S_TKEEP[i] ? S_TDATA[8*i +: 8] : (w_keep_sh[i] ? 8'h06 : 8'h00);
        if (w_at_end && w_partial) w_lane[63:56] = w_lane[63:56] | 8'h80;
    end

    // absorb FSM: all outputs are registered alongside the state
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_var       <= '0;
            r_final     <= 1'b0;
            r_need06    <= 1'b0;
            r_need80    <= 1'b0;
            r_fresh     <= 1'b0;
            r_tready    <= 1'b0;
            r_clr       <= 1'b0;
            r_we        <= 1'b0;
            r_perm      <= 1'b0;
            r_sq        <= 1'b0;
            r_busy      <= 1'b0;
            r_lane_idx  <= '0;
            r_lane_data <= '0;
        end else begin
            r_clr  <= 1'b0;
            r_we   <= 1'b0;
            r_perm <= 1'b0;
            case (r_state)
                S_IDLE: if (S_TVALID) begin
                    r_var    <= S_TUSER;
                    r_clr    <= 1'b1;
                    r_idx    <= '0;
                    r_tready <= 1'b1;
                    r_busy   <= 1'b1;
                    r_state  <= S_ABSORB;
                end
                S_ABSORB: if (S_TVALID) begin
                    r_we        <= 1'b1;
                    r_lane_idx  <= r_idx;
                    r_lane_data <= S_TLAST ? w_lane : S_TDATA;
                    if (!S_TLAST) begin
                        if (w_at_end) begin
                            r_tready <= 1'b0;
                            r_state  <= S_START;
                        end else
                            r_idx <= r_idx + 5'd1;
                    end else begin
                        r_tready <= 1'b0;
                        r_final  <= 1'b1;
                        if (w_partial) begin
                            r_need80 <= !w_at_end;
                            r_state  <= w_at_end ? S_START : S_PAD;
                        end else begin
                            r_need06 <= 1'b1;
                            r_need80 <= 1'b1;
                            r_fresh  <= w_at_end;
                            r_idx    <= w_at_end ? 5'd0 : r_idx + 5'd1;
                            r_state  <= w_at_end ? S_START : S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    r_we <= 1'b1;
                    if (r_need06) begin
                        r_lane_idx  <= r_idx;
                        r_lane_data <= {(r_idx == w_rate_m1) ? 8'h80 : 8'h00, 48'h0, 8'h06};
                        r_need06    <= 1'b0;
                        if (r_idx == w_rate_m1) begin
                            r_need80 <= 1'b0;
                            r_state  <= S_START;
                        end
                    end else begin
                        r_lane_idx  <= w_rate_m1;
                        r_lane_data <= 64'h8000_0000_0000_0000;
                        r_need80    <= 1'b0;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    r_perm  <= 1'b1;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (PERM_DONE) begin
                    if (r_fresh) begin
                        r_fresh <= 1'b0;
                        r_state <= S_PAD;
                    end else if (r_final) begin
                        r_sq    <= 1'b1;
                        r_state <= S_SQUEEZE;
                    end else begin
                        r_idx    <= '0;
                        r_tready <= 1'b1;
                        r_state  <= S_ABSORB;
                    end
                end
                S_SQUEEZE: if (SQ_LAST) begin
                    r_sq     <= 1'b0;
                    r_busy   <= 1'b0;
                    r_final  <= 1'b0;
                    r_need06 <= 1'b0;
                    r_need80 <= 1'b0;
                    r_fresh  <= 1'b0;
                    r_idx    <= '0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign S_TREADY   = r_tready;
    assign STATE_CLR  = r_clr;
    assign LANE_WE    = r_we;
    assign LANE_IDX   = r_lane_idx;
    assign LANE_DATA  = r_lane_data;
    assign PERM_START = r_perm;
    assign SQ_READY   = r_sq;
    assign SQ_TUSER   = r_var;
    assign BUSY       = r_busy;
endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// tb_sha3_absorb_ctrl: directed message vectors plus an asynchronous-reset sequence for sha3_absorb_ctrl.
module tb_sha3_absorb_ctrl;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [63:0] S_TDATA = '0;
    logic [7:0]  S_TKEEP = '0;
    logic [1:0]  S_TUSER = '0;
    logic        S_TVALID = 1'b0;
    logic        S_TLAST = 1'b0;
    logic        S_TREADY;
    logic        STATE_CLR;
    logic        LANE_WE;
    logic [4:0]  LANE_IDX;
    logic [63:0] LANE_DATA;
    logic        PERM_START;
    logic        PERM_DONE;
    logic        SQ_READY;
    logic [1:0]  SQ_TUSER;
    logic        SQ_LAST = 1'b0;
    logic        BUSY;

    logic auto_pd = 1'b0;
    logic man_pd = 1'b0;
    bit   auto_done = 1'b1;
    assign PERM_DONE = auto_pd | man_pd;

    sha3_absorb_ctrl #(.LANE_W(64)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP), .S_TUSER(S_TUSER),
        .S_TVALID(S_TVALID), .S_TLAST(S_TLAST), .S_TREADY(S_TREADY),
        .STATE_CLR(STATE_CLR), .LANE_WE(LANE_WE), .LANE_IDX(LANE_IDX), .LANE_DATA(LANE_DATA),
        .PERM_START(PERM_START), .PERM_DONE(PERM_DONE),
        .SQ_READY(SQ_READY), .SQ_TUSER(SQ_TUSER), .SQ_LAST(SQ_LAST), .BUSY(BUSY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int          c;
        logic [4:0]  i;
        logic [63:0] d;
    } wr_t;

    typedef struct {
        logic [1:0]  vr;
        int          rate;
        int          nb;
        logic [7:0]  keep;
        logic [63:0] ld;
        logic [63:0] lw;
        logic [4:0]  lidx;
        int          nw;
        int          np;
        logic [4:0]  p1i;
        logic [63:0] p1d;
        logic [4:0]  fi;
        logic [63:0] fd;
    } vec_t;

    wr_t        wq[$];
    int         cyc = 0;
    int         perm_cnt = 0;
    int         clr_cnt = 0;
    int         clr_cyc = 0;
    int         tready_bad = 0;
    bit         outstanding = 1'b0;
    logic [4:0] cur_rm1 = '0;
    int         n_cmp = 0;
    int         n_err = 0;
    vec_t       tv[11];

    // passive monitor: logs lane writes, permutation requests, clears and S_TREADY misuse
    always @(negedge ACLK) begin
        cyc <= cyc + 1;
        if (!ARESETN) outstanding <= 1'b0;
        else begin
            if (S_TREADY && (outstanding || PERM_START || (LANE_WE && LANE_IDX == cur_rm1)))
                tready_bad <= tready_bad + 1;
            if (LANE_WE) wq.push_back('{cyc, LANE_IDX, LANE_DATA});
            if (PERM_START) perm_cnt <= perm_cnt + 1;
            outstanding <= PERM_START ? 1'b1 : PERM_DONE ? 1'b0 : outstanding;
            if (STATE_CLR) begin
                clr_cnt <= clr_cnt + 1;
                clr_cyc <= cyc;
            end
        end
    end

    // Keccak core stand-in: PERM_DONE three cycles after PERM_START
    initial forever begin
        @(negedge ACLK);
        if (PERM_START && auto_done) begin
            repeat (3) @(posedge ACLK);
            #1 auto_pd = 1'b1;
            @(posedge ACLK);
            #1 auto_pd = 1'b0;
        end
    end

    // output stage stand-in: SQ_LAST two cycles into the squeeze
    initial forever begin
        @(negedge ACLK);
        if (SQ_READY) begin
            repeat (2) @(posedge ACLK);
            #1 SQ_LAST = 1'b1;
            @(posedge ACLK);
            #1 SQ_LAST = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] word(input int k, input int b);
        return {8'(k), 8'hC0, 16'(b), 32'hDEAD_BEEF};
    endfunction

    task automatic drive_beat(input logic [1:0] u, input logic [63:0] d, input logic [7:0] kp, input logic lst);
        int g = 0;
        S_TVALID = 1'b1;
        S_TDATA  = d;
        S_TKEEP  = kp;
        S_TUSER  = u;
        S_TLAST  = lst;
        do begin
            @(negedge ACLK);
            g++;
        end while (!S_TREADY && g < 200);
        if (!S_TREADY) chk("beat_timeout", {63'd0, S_TREADY}, 64'd1);
        @(posedge ACLK);
        #1;
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
        S_TKEEP  = '0;
    endtask

    task automatic wait_sq(input logic lvl, input string nm);
        int g = 0;
        do begin
            @(negedge ACLK);
            g++;
        end while (SQ_READY !== lvl && g < 500);
        chk(nm, {63'd0, SQ_READY}, {63'd0, lvl});
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int   bw, bp, bc, bt, nw, errs;
        v    = tv[k];
        bw   = wq.size();
        bp   = perm_cnt;
        bc   = clr_cnt;
        bt   = tready_bad;
        errs = 0;
        cur_rm1 = 5'(v.rate - 1);
        for (int b = 0; b < v.nb; b++) begin
            if (b == v.nb - 1) drive_beat(b == 0 ? v.vr : ~v.vr, v.ld, v.keep, 1'b1);
            else drive_beat(b == 0 ? v.vr : ~v.vr, word(k, b), 8'hFF, 1'b0);
        end
        wait_sq(1'b1, $sformatf("v%0d_sq_rise", k));
        chk($sformatf("v%0d_sq_tuser", k), {62'd0, SQ_TUSER}, {62'd0, v.vr});
        chk($sformatf("v%0d_busy_sq", k), {63'd0, BUSY}, 64'd1);
        chk($sformatf("v%0d_tready_sq", k), {63'd0, S_TREADY}, 64'd0);
        wait_sq(1'b0, $sformatf("v%0d_sq_fall", k));
        chk($sformatf("v%0d_busy_idle", k), {63'd0, BUSY}, 64'd0);
        nw = wq.size() - bw;
        chk($sformatf("v%0d_writes", k), 64'(nw), 64'(v.nw));
        if (nw == v.nw) begin
            if (v.nb > 1) begin
                for (int b = 0; b < v.nb - 1; b++)
                    if (wq[bw+b].i !== 5'(b % v.rate) || wq[bw+b].d !== word(k, b)) errs++;
                chk($sformatf("v%0d_msg_lanes_bad", k), 64'(errs), 64'd0);
            end
            chk($sformatf("v%0d_last_idx", k), 64'(wq[bw+v.nb-1].i), 64'(v.lidx));
            chk($sformatf("v%0d_last_data", k), wq[bw+v.nb-1].d, v.lw);
            if (v.nw > v.nb) begin
                chk($sformatf("v%0d_pad1_idx", k), 64'(wq[bw+v.nb].i), 64'(v.p1i));
                chk($sformatf("v%0d_pad1_data", k), wq[bw+v.nb].d, v.p1d);
            end
            chk($sformatf("v%0d_final_idx", k), 64'(wq[bw+nw-1].i), 64'(v.fi));
            chk($sformatf("v%0d_final_data", k), wq[bw+nw-1].d, v.fd);
            chk($sformatf("v%0d_clr_before_write", k), {63'd0, clr_cyc < wq[bw].c}, 64'd1);
        end
        chk($sformatf("v%0d_perms", k), 64'(perm_cnt - bp), 64'(v.np));
        chk($sformatf("v%0d_clr_pulses", k), 64'(clr_cnt - bc), 64'd1);
        chk($sformatf("v%0d_tready_violations", k), 64'(tready_bad - bt), 64'd0);
    endtask

    initial begin
        int g;
        //        vr rate nb keep   last raw data           expected last lane     lidx nw np p1i p1d                    fi  fd
        tv[0]  = '{1, 17,  1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0006,  0,  2, 1, 16, 64'h8000_0000_0000_0000, 16, 64'h8000_0000_0000_0000};
        tv[1]  = '{3,  9,  9, 8'h07, 64'hFFFF_FFFF_FF63_6261, 64'h8000_0000_0663_6261,  8,  9, 1,  8, 64'h8000_0000_0663_6261,  8, 64'h8000_0000_0663_6261};
        tv[2]  = '{0, 18, 18, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 17, 20, 2,  0, 64'h0000_0000_0000_0006, 17, 64'h8000_0000_0000_0000};
        tv[3]  = '{2, 13, 13, 8'hFF, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, 12, 15, 2,  0, 64'h0000_0000_0000_0006, 12, 64'h8000_0000_0000_0000};
        tv[4]  = '{1, 17, 16, 8'hFF, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 15, 17, 1, 16, 64'h8000_0000_0000_0006, 16, 64'h8000_0000_0000_0006};
        tv[5]  = '{0, 18,  3, 8'h1F, 64'hFFFF_FFAA_BBCC_DDEE, 64'h0000_06AA_BBCC_DDEE,  2,  4, 1, 17, 64'h8000_0000_0000_0000, 17, 64'h8000_0000_0000_0000};
        tv[6]  = '{2, 13, 13, 8'h7F, 64'h33AA_BBCC_DDEE_FF11, 64'h86AA_BBCC_DDEE_FF11, 12, 13, 1, 12, 64'h86AA_BBCC_DDEE_FF11, 12, 64'h86AA_BBCC_DDEE_FF11};
        tv[7]  = '{3,  9, 20, 8'h0F, 64'h9988_7766_1234_5678, 64'h0000_0006_1234_5678,  1, 21, 3,  8, 64'h8000_0000_0000_0000,  8, 64'h8000_0000_0000_0000};
        tv[8]  = '{1, 17, 17, 8'hFF, 64'hAAAA_5555_AAAA_5555, 64'hAAAA_5555_AAAA_5555, 16, 19, 2,  0, 64'h0000_0000_0000_0006, 16, 64'h8000_0000_0000_0000};
        tv[9]  = '{3,  9,  8, 8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0F0F_0F0F_0F0F,  7,  9, 1,  8, 64'h8000_0000_0000_0006,  8, 64'h8000_0000_0000_0006};
        tv[10] = '{0, 18, 18, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0006, 17, 18, 1, 17, 64'h8000_0000_0000_0006, 17, 64'h8000_0000_0000_0006};

        repeat (3) @(negedge ACLK);
        chk("rst_busy", {63'd0, BUSY}, 64'd0);
        chk("rst_tready", {63'd0, S_TREADY}, 64'd0);
        chk("rst_sq_ready", {63'd0, SQ_READY}, 64'd0);
        chk("rst_sq_tuser", {62'd0, SQ_TUSER}, 64'd0);
        chk("rst_state_clr", {63'd0, STATE_CLR}, 64'd0);
        chk("rst_lane_we", {63'd0, LANE_WE}, 64'd0);
        chk("rst_perm_start", {63'd0, PERM_START}, 64'd0);
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        @(negedge ACLK);
        chk("idle_no_valid_busy", {63'd0, BUSY}, 64'd0);

        for (int k = 0; k < 11; k++) run_vec(k);

        // reset while the core is permuting a non-final block
        auto_done = 1'b0;
        cur_rm1 = 5'd16;
        for (int b = 0; b < 17; b++) drive_beat(b == 0 ? 2'd1 : 2'd2, word(20, b), 8'hFF, 1'b0);
        g = 0;
        do begin
            @(negedge ACLK);
            g++;
        end while (!PERM_START && g < 50);
        chk("arst_perm_start_seen", {63'd0, PERM_START}, 64'd1);
        @(negedge ACLK);
        chk("arst_busy_before", {63'd0, BUSY}, 64'd1);
        chk("arst_sq_tuser_before", {62'd0, SQ_TUSER}, 64'd1);
        #2 ARESETN = 1'b0;
        #1;
        chk("arst_busy", {63'd0, BUSY}, 64'd0);
        chk("arst_tready", {63'd0, S_TREADY}, 64'd0);
        chk("arst_sq_ready", {63'd0, SQ_READY}, 64'd0);
        chk("arst_sq_tuser", {62'd0, SQ_TUSER}, 64'd0);
        chk("arst_lane_idx", {59'd0, LANE_IDX}, 64'd0);
        chk("arst_lane_data", LANE_DATA, 64'd0);
        chk("arst_perm_start", {63'd0, PERM_START}, 64'd0);
        @(negedge ACLK);
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        man_pd = 1'b1;
        @(posedge ACLK);
        #1 man_pd = 1'b0;
        @(negedge ACLK);
        chk("late_done_busy", {63'd0, BUSY}, 64'd0);
        chk("late_done_tready", {63'd0, S_TREADY}, 64'd0);
        chk("late_done_sq_ready", {63'd0, SQ_READY}, 64'd0);
        auto_done = 1'b1;
        run_vec(0);
        run_vec(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
